// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operand-entry front end.
//   - state_e      : entry sequencer states
//   - CALC_W       : default operand/result width
//   - CALC_CNT_W   : default completed-operation counter width
//   - STEP_*       : LED codes shown on the step output
//   - opcode names : CombCalc opcode values (passed through, never decoded here)
package calc_pkg;

    localparam int unsigned CALC_W     = 4;
    localparam int unsigned CALC_CNT_W = 8;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned STEP_W     = 3;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_e;

    localparam logic [STEP_W-1:0] STEP_GET_A  = 3'b001;
    localparam logic [STEP_W-1:0] STEP_GET_B  = 3'b010;
    localparam logic [STEP_W-1:0] STEP_GET_OP = 3'b100;
    localparam logic [STEP_W-1:0] STEP_RUN    = 3'b111;

    localparam logic [OP_W-1:0] ADD_AB = 3'b000;
    localparam logic [OP_W-1:0] SUB_AB = 3'b001;
    localparam logic [OP_W-1:0] AND_AB = 3'b010;
    localparam logic [OP_W-1:0] OR_AB  = 3'b011;
    localparam logic [OP_W-1:0] XOR_AB = 3'b100;
    localparam logic [OP_W-1:0] NOT_A  = 3'b101;
    localparam logic [OP_W-1:0] NEG_A  = 3'b110;
    localparam logic [OP_W-1:0] PASS_B = 3'b111;

    // LED code for a given state; EXEC and SHOW share the "running" code.
    function automatic logic [STEP_W-1:0] step_code(input state_e st);
        logic [STEP_W-1:0] code;
        code = STEP_RUN;
        case (st)
            ST_GET_A:  code = STEP_GET_A;
            ST_GET_B:  code = STEP_GET_B;
            ST_GET_OP: code = STEP_GET_OP;
            default:   code = STEP_RUN;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/calc_entry_seq.sv
// Sequential operand-entry front end for the combinational calculator.
// Collects A, B and an opcode from the switches over successive enter pulses,
// presents them registered to CombCalc, latches its result one cycle later,
// and lets the previous result be chained back in as the next A.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   SW, enter, clear    : switch value and debounced one-cycle pulses
//   calc_A/B/OP         : registered operands/opcode to CombCalc
//   calc_R, calc_ovf    : combinational result from CombCalc
//   R_out, ovf_out      : latched result and its overflow flag
//   ovf_sticky          : any overflow since last clear/reset
//   done                : one-cycle pulse when a new result is latched
//   step                : LED code for the current state
//   op_count            : saturating count of completed operations
module calc_entry_seq
    import calc_pkg::*;
#(
    parameter int unsigned W     = CALC_W,
    parameter int unsigned CNT_W = CALC_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       SW,
    input  logic               enter,
    input  logic               clear,
    output logic [W-1:0]       calc_A,
    output logic [W-1:0]       calc_B,
    output logic [OP_W-1:0]    calc_OP,
    input  logic [W-1:0]       calc_R,
    input  logic               calc_ovf,
    output logic [W-1:0]       R_out,
    output logic               ovf_out,
    output logic               ovf_sticky,
    output logic               done,
    output logic [STEP_W-1:0]  step,
    output logic [CNT_W-1:0]   op_count
);

    state_e              state_q,  state_d;
    logic [W-1:0]        a_q,      a_d;
    logic [W-1:0]        b_q,      b_d;
    logic [OP_W-1:0]     op_q,     op_d;
    logic [W-1:0]        r_q,      r_d;
    logic                ovf_q,    ovf_d;
    logic                sticky_q, sticky_d;
    logic                done_q,   done_d;
    logic [STEP_W-1:0]   step_q,   step_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;

    // Next-state and register-update logic; clear overrides every state.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        r_d      = r_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;

        if (clear) begin
            // A clear landing on EXEC discards that result and does not count it.
            state_d  = ST_GET_A;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            r_d      = '0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
        end else begin
            case (state_q)
                ST_GET_A: begin
                    if (enter) begin
                        a_d     = SW;
                        state_d = ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (enter) begin
                        b_d     = SW;
                        state_d = ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (enter) begin
                        op_d    = SW[OP_W-1:0];
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // CombCalc has had one full cycle on the registered operands.
                    r_d      = calc_R;
                    ovf_d    = calc_ovf;
                    sticky_d = sticky_q | calc_ovf;
                    done_d   = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d  = ST_SHOW;
                end
                ST_SHOW: begin
                    // Chain: the wrapped result becomes A, B and OP are kept.
                    if (enter) begin
                        a_d     = r_q;
                        state_d = ST_GET_B;
                    end
                end
                default: begin
                    state_d = ST_GET_A;
                end
            endcase
        end

        step_d = step_code(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_GET_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            done_q   <= 1'b0;
            step_q   <= STEP_GET_A;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            done_q   <= done_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

    assign calc_A     = a_q;
    assign calc_B     = b_q;
    assign calc_OP    = op_q;
    assign R_out      = r_q;
    assign ovf_out    = ovf_q;
    assign ovf_sticky = sticky_q;
    assign done       = done_q;
    assign step       = step_q;
    assign op_count   = cnt_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Self-checking bench for calc_entry_seq with a behavioural CombCalc stand-in
// and a transaction-level reference model of the entry sequence.
module tb_calc_entry_seq;
    import calc_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    localparam int PH_A    = 0;
    localparam int PH_B    = 1;
    localparam int PH_OP   = 2;
    localparam int PH_EXEC = 3;
    localparam int PH_SHOW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     SW;
    logic             enter;
    logic             clear;
    logic [W-1:0]     calc_A;
    logic [W-1:0]     calc_B;
    logic [2:0]       calc_OP;
    logic [W-1:0]     calc_R;
    logic             calc_ovf;
    logic [W-1:0]     R_out;
    logic             ovf_out;
    logic             ovf_sticky;
    logic             done;
    logic [2:0]       step;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    calc_entry_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .SW         (SW),
        .enter      (enter),
        .clear      (clear),
        .calc_A     (calc_A),
        .calc_B     (calc_B),
        .calc_OP    (calc_OP),
        .calc_R     (calc_R),
        .calc_ovf   (calc_ovf),
        .R_out      (R_out),
        .ovf_out    (ovf_out),
        .ovf_sticky (ovf_sticky),
        .done       (done),
        .step       (step),
        .op_count   (op_count)
    );

    // CombCalc stand-in, signed 4-bit arithmetic; returns {ovf, result}.
    function automatic logic [4:0] comb_calc(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        int sa, sb, res;
        logic [3:0] r;
        logic ov;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        res = 0;
        ov = 1'b0;
        r = 4'd0;
        case (op)
            3'b000: res = sa + sb;
            3'b001: res = sa - sb;
            3'b101: res = -sa - 1;
            3'b110: res = -sa;
            3'b111: res = sb;
            default: res = 0;
        endcase
        case (op)
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            default: begin
                ov = (res > 7) || (res < -8);
                r  = 4'(res);
            end
        endcase
        return {ov, r};
    endfunction

    assign {calc_ovf, calc_R} = comb_calc(calc_A, calc_B, calc_OP);

    // Reference model: what the entry sequence must show after each clock.
    int         m_phase;
    logic [3:0] m_a, m_b, m_r;
    logic [2:0] m_op;
    logic       m_ovf, m_sticky, m_done;
    int         m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = PH_A; m_a = 0; m_b = 0; m_op = 0; m_r = 0;
            m_ovf = 0; m_sticky = 0; m_done = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (clear) begin
                m_phase = PH_A; m_a = 0; m_b = 0; m_op = 0; m_r = 0;
                m_ovf = 0; m_sticky = 0;
            end else if (m_phase == PH_A) begin
                if (enter) begin m_a = SW; m_phase = PH_B; end
            end else if (m_phase == PH_B) begin
                if (enter) begin m_b = SW; m_phase = PH_OP; end
            end else if (m_phase == PH_OP) begin
                if (enter) begin m_op = SW[2:0]; m_phase = PH_EXEC; end
            end else if (m_phase == PH_EXEC) begin
                {m_ovf, m_r} = comb_calc(m_a, m_b, m_op);
                m_sticky = m_sticky | m_ovf;
                m_done = 1;
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_phase = PH_SHOW;
            end else begin
                if (enter) begin m_a = m_r; m_phase = PH_B; end
            end
        end
    end

    function automatic logic [2:0] exp_step(input int ph);
        if (ph == PH_A)  return 3'b001;
        if (ph == PH_B)  return 3'b010;
        if (ph == PH_OP) return 3'b100;
        return 3'b111;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("m_calc_A",   32'(calc_A),     32'(m_a));
        chk("m_calc_B",   32'(calc_B),     32'(m_b));
        chk("m_calc_OP",  32'(calc_OP),    32'(m_op));
        chk("m_R_out",    32'(R_out),      32'(m_r));
        chk("m_ovf_out",  32'(ovf_out),    32'(m_ovf));
        chk("m_sticky",   32'(ovf_sticky), 32'(m_sticky));
        chk("m_done",     32'(done),       32'(m_done));
        chk("m_step",     32'(step),       32'(exp_step(m_phase)));
        chk("m_op_count", 32'(op_count),   32'(m_cnt));
    endtask

    // Drive inputs for one clock, then compare against the model after that edge.
    task automatic tick(input logic e, input logic c, input logic [3:0] s);
        enter = e;
        clear = c;
        SW    = s;
        @(negedge clk);
        compare_model();
        #1;
    endtask

    initial begin
        rst = 1'b1; enter = 0; clear = 0; SW = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_step",   32'(step), 32'(3'b001));
        chk("rst_calc_A", 32'(calc_A), 0);
        chk("rst_count",  32'(op_count), 0);
        chk("rst_done",   32'(done), 0);
        rst = 1'b0;

        // 3 + 2: done two cycles after the opcode enter; enter during EXEC ignored.
        tick(1, 0, 4'd3);
        tick(1, 0, 4'd2);
        tick(1, 0, 4'd0);
        chk("t1_done_exec", 32'(done), 0);
        chk("t1_step_exec", 32'(step), 32'(3'b111));
        tick(1, 0, 4'd9);
        chk("t1_done",  32'(done), 1);
        chk("t1_R",     32'(R_out), 5);
        chk("t1_ovf",   32'(ovf_out), 0);
        chk("t1_count", 32'(op_count), 1);
        chk("t1_A_kept", 32'(calc_A), 3);

        // 7 + 1 overflows to -8, then chain +1 gives -7.
        tick(0, 1, 4'd0);
        tick(1, 0, 4'd7);
        tick(1, 0, 4'd1);
        tick(1, 0, 4'd0);
        tick(0, 0, 4'd0);
        chk("t2_R",      32'(R_out), 32'h8);
        chk("t2_ovf",    32'(ovf_out), 1);
        chk("t2_sticky", 32'(ovf_sticky), 1);
        tick(1, 0, 4'd0);
        chk("t2_chainA", 32'(calc_A), 32'h8);
        chk("t2_chstep", 32'(step), 32'(3'b010));
        tick(1, 0, 4'd1);
        tick(1, 0, 4'd0);
        tick(0, 0, 4'd0);
        chk("t2c_R",      32'(R_out), 32'h9);
        chk("t2c_ovf",    32'(ovf_out), 0);
        chk("t2c_sticky", 32'(ovf_sticky), 1);
        chk("t2c_count",  32'(op_count), 3);

        // Clear in GET_OP.
        tick(0, 1, 4'd0);
        tick(1, 0, 4'd5);
        tick(1, 0, 4'd4);
        tick(0, 1, 4'd0);
        chk("t3_step",   32'(step), 32'(3'b001));
        chk("t3_A",      32'(calc_A), 0);
        chk("t3_B",      32'(calc_B), 0);
        chk("t3_sticky", 32'(ovf_sticky), 0);
        chk("t3_count",  32'(op_count), 3);

        // 2 - 3 = -1, then enter and clear together in SHOW.
        tick(1, 0, 4'd2);
        tick(1, 0, 4'd3);
        tick(1, 0, 4'd1);
        tick(0, 0, 4'd0);
        chk("t4_R", 32'(R_out), 32'hF);
        tick(1, 1, 4'd0);
        chk("t4_step",  32'(step), 32'(3'b001));
        chk("t4_A",     32'(calc_A), 0);
        chk("t4_R0",    32'(R_out), 0);
        chk("t4_count", 32'(op_count), 4);

        // Reset while in EXEC.
        tick(1, 0, 4'd1);
        tick(1, 0, 4'd1);
        tick(1, 0, 4'd0);
        chk("t5_in_exec", 32'(step), 32'(3'b111));
        rst = 1'b1;
        #1;
        chk("t5_step",  32'(step), 32'(3'b001));
        chk("t5_A",     32'(calc_A), 0);
        chk("t5_count", 32'(op_count), 0);
        chk("t5_done",  32'(done), 0);
        tick(0, 0, 4'd0);
        rst = 1'b0;
        tick(0, 0, 4'd0);
        chk("t5_done_after",  32'(done), 0);
        chk("t5_count_after", 32'(op_count), 0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                 4'($urandom_range(0, 15)));
        end

        // Held-high enter drives continuous chained ops into saturation.
        for (int i = 0; i < 1200; i++) begin
            tick(1'b1, 1'b0, 4'($urandom_range(0, 15)));
        end
        chk("sat_count", 32'(op_count), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_entry_seq.md
# calc_entry_seq

Sequential operand-entry front end for the 4-bit combinational calculator (CombCalc).
- Collects A, B and a 3-bit opcode from slide switches over successive enter presses, and drives them into the calculator.
- Registers the calculator's combinational R/ovf, and supports chaining the previous result back in as the next A.
- Sits directly upstream of CombCalc; its registered result outputs feed the board display logic.

## Interface
- W, 4, operand/result width (two's complement)
- CNT_W, 8, width of completed-operation counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- SW  in  W  switch value; SW[2:0] doubles as opcode
- enter  in  1  one-cycle pulse, already debounced/synchronised
- clear  in  1  one-cycle pulse, already debounced/synchronised
- calc_A  out  W  operand A to CombCalc (registered)
- calc_B  out  W  operand B to CombCalc (registered)
- calc_OP  out  3  opcode to CombCalc (registered)
- calc_R  in  W  combinational result from CombCalc
- calc_ovf  in  1  combinational overflow from CombCalc
- R_out  out  W  latched result
- ovf_out  out  1  overflow of latched result
- ovf_sticky  out  1  set by any overflow since last clear/reset
- done  out  1  one-cycle pulse, new result latched
- step  out  3  one-hot-ish LED code: 001 GET_A, 010 GET_B, 100 GET_OP, 111 EXEC/SHOW
- op_count  out  CNT_W  completed operations, saturating

## Operation
- FSM states: GET_A, GET_B, GET_OP, EXEC, SHOW.
- GET_A: on enter, SW to A register; go to GET_B.
- GET_B: on enter, SW to B register; go to GET_OP.
- GET_OP: on enter, SW[2:0] to OP register; go to EXEC.
- EXEC: lasts exactly one cycle; enter ignored.
  - calc_R and calc_ovf are sampled into R_out and ovf_out.
  - ovf_sticky is ORed with calc_ovf.
  - op_count is incremented, saturating at all-ones.
  - Go to SHOW.
- SHOW: hold outputs.
  - enter: chain. R_out is copied to the A register; B and OP are unchanged until re-entered; go to GET_B.
  - A chained value with ovf_out=1 is the wrapped W-bit value, used as-is.
- clear, in any state: go to GET_A; zero A, B, OP, R_out, ovf_out, ovf_sticky. op_count is kept.
- enter and clear in the same cycle: clear wins.
- Opcode values are passed through uninterpreted; decoding belongs to CombCalc.

## Timing
- Reset, asynchronous and immediate: state GET_A; all outputs 0 (calc_A, calc_B, calc_OP, R_out, ovf_out, ovf_sticky, done, op_count); step=001.
- Reset mid-EXEC: result discarded, op_count not incremented.
- Operand capture: enter in cycle n makes the new value visible on calc_* in cycle n+1.
- Op latency: enter in GET_OP at cycle n gives:
  - EXEC during n+1 (CombCalc settles from registered inputs);
  - R_out/ovf_out updated and done=1 during n+2, the first SHOW cycle.
- done is high for exactly one cycle per EXEC.
- Chain enter at SHOW cycle m: calc_A=R_out from m+1; state GET_B at m+1.
- Single-cycle combinational path through CombCalc must meet clk period; no multicycle.

## Structure
- calc_pkg holds:
  - state enum;
  - default W;
  - step LED code constants;
  - opcode localparams (ADD_AB=3'b000 etc.) for bench use.
- Single module; no sub-module needed.
- CombCalc is instantiated alongside this block by the top level, not inside it.

## Test plan
- Reset, then enter SW=3, enter SW=2, enter SW=000, with CombCalc connected: done pulses two cycles after the third enter; R_out=5, ovf_out=0, op_count=1.
- A=7, B=1, OP=000: R_out=-8 (4'b1000), ovf_out=1, ovf_sticky=1.
  - Then chain with B=1, OP=000: R_out=-7, ovf_out=0, ovf_sticky stays 1.
- Clear asserted in GET_OP after A=5, B=4: state GET_A; calc_A=calc_B=0; ovf_sticky=0; op_count unchanged.
- enter and clear in the same SHOW cycle: state GET_A, registers zeroed, no chain.
- enter pulses during EXEC and a held-high enter: each pulse advances exactly one state; EXEC always lasts one cycle.
- rst asserted mid-EXEC: outputs zero immediately, done never pulses, op_count=0.
- 256 ops with CNT_W=8: op_count saturates at 255.
